// File: rtl/c2_sn_window_update.sv
// Slides the M_PITCH-sample sn window left by N_SAMP and appends N_SAMP new samples
// (speech RAM or zeros); each sample costs RD_LAT+2 cycles, start is ignored while busy.
module c2_sn_window_update #(
   parameter int N       = 32,
   parameter int AW      = 10,
   parameter int N_SAMP  = 80,
   parameter int M_PITCH = 320,
   parameter int RD_LAT  = 2
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start_frame,
   input  logic [AW-1:0] i_frame_base,
   input  logic          i_shift_en,
   input  logic          i_load_zero,
   output logic [AW-1:0] o_spch_addr,
   output logic          o_spch_re,
   input  logic [N-1:0]  i_spch_q,
   output logic [AW-1:0] o_sn_addr,
   output logic [N-1:0]  o_sn_wdata,
   output logic          o_sn_re,
   output logic          o_sn_we,
   input  logic [N-1:0]  i_sn_q,
   output logic          o_busy,
   output logic          o_done_frame,
   output logic [N-1:0]  o_checksum
);

   typedef enum logic [2:0] {
      IDLE, SH_RD, SH_WAIT, SH_WR, LD_RD, LD_WAIT, LD_WR, DONE
   } state_t;

   localparam int            WW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [WW-1:0] W_LAST    = WW'(RD_LAT - 1);
   localparam bit            HAS_SHIFT = (N_SAMP < M_PITCH);
   localparam logic [AW-1:0] SH_LAST   = AW'(M_PITCH - N_SAMP - 1);
   localparam logic [AW-1:0] LD_LAST   = AW'(N_SAMP - 1);
   localparam logic [AW-1:0] OFS_N     = AW'(N_SAMP);
   localparam logic [AW-1:0] OFS_LD    = AW'(M_PITCH - N_SAMP);

   state_t        r_state, w_next;
   logic [AW-1:0] r_k;
   logic [WW-1:0] r_wcnt;
   logic [N-1:0]  r_data;
   logic [N-1:0]  r_cks;
   logic [AW-1:0] r_base;
   logic          r_zero;
   logic          w_wlast;

   assign w_wlast    = (r_wcnt == W_LAST);
   assign o_checksum = r_cks;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      o_spch_addr  = '0;
      o_spch_re    = 1'b0;
      o_sn_addr    = '0;
      o_sn_wdata   = '0;
      o_sn_re      = 1'b0;
      o_sn_we      = 1'b0;
      o_done_frame = 1'b0;
      o_busy       = (r_state != IDLE);
      unique case (r_state)
         IDLE: begin
            if (i_start_frame) w_next = (i_shift_en && HAS_SHIFT) ? SH_RD : LD_RD;
         end
         SH_RD: begin
            o_sn_addr = r_k + OFS_N;
            o_sn_re   = 1'b1;
            w_next    = SH_WAIT;
         end
         SH_WAIT: begin
            // address held so RAMs without an input register still see it
            o_sn_addr = r_k + OFS_N;
            o_sn_re   = 1'b1;
            if (w_wlast) w_next = SH_WR;
         end
         SH_WR: begin
            o_sn_addr  = r_k;
            o_sn_we    = 1'b1;
            o_sn_wdata = r_data;
            w_next     = (r_k == SH_LAST) ? LD_RD : SH_RD;
         end
         LD_RD: begin
            o_spch_addr = r_base + r_k;
            o_spch_re   = !r_zero;
            w_next      = LD_WAIT;
         end
         LD_WAIT: begin
            if (w_wlast) w_next = LD_WR;
         end
         LD_WR: begin
            o_sn_addr  = OFS_LD + r_k;
            o_sn_we    = 1'b1;
            o_sn_wdata = r_data;
            w_next     = (r_k == LD_LAST) ? DONE : LD_RD;
         end
         DONE: begin
            o_done_frame = 1'b1;
            w_next       = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_k    <= '0;
         r_wcnt <= '0;
         r_data <= '0;
         r_cks  <= '0;
         r_base <= '0;
         r_zero <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (i_start_frame) begin
                  r_base <= i_frame_base;
                  r_zero <= i_load_zero;
                  r_k    <= '0;
                  r_wcnt <= '0;
                  r_cks  <= '0;
               end
            end
            SH_WAIT: begin
               if (w_wlast) begin
                  r_data <= i_sn_q;
                  r_wcnt <= '0;
               end else begin
                  r_wcnt <= r_wcnt + 1'b1;
               end
            end
            SH_WR: r_k <= (r_k == SH_LAST) ? '0 : r_k + 1'b1;
            LD_WAIT: begin
               if (w_wlast) begin
                  r_data <= r_zero ? '0 : i_spch_q;
                  r_wcnt <= '0;
               end else begin
                  r_wcnt <= r_wcnt + 1'b1;
               end
            end
            LD_WR: begin
               r_k   <= r_k + 1'b1;
               r_cks <= r_cks + r_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_c2_sn_window_update.sv
// Bench: three window-updater configurations (default, RD_LAT=3, N_SAMP=M_PITCH=8)
// against RAM models; expected sn writes are queued at start and popped on each write.
module tb_c2_sn_window_update;

   typedef struct packed {
      logic [9:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start     [3];
   logic [9:0]  base      [3];
   logic        sh        [3];
   logic        lz        [3];
   logic        preload   [3];
   logic [9:0]  spch_addr [3];
   logic        spch_re   [3];
   logic [31:0] spch_q    [3];
   logic [9:0]  sn_addr   [3];
   logic [31:0] sn_wdata  [3];
   logic        sn_re     [3];
   logic        sn_we     [3];
   logic [31:0] sn_q      [3];
   logic        busy      [3];
   logic        done      [3];
   logic [31:0] cks       [3];

   int   ncmp = 0;
   int   nerr = 0;
   int   n_extra, n_overlap, n_spch;
   int   mdl [1024];
   wr_t  exp_q [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_u
      localparam int LAT = (g == 0) ? 2 : (g == 1) ? 3 : 1;
      localparam int NS  = (g == 2) ? 8 : 80;
      localparam int MP  = (g == 2) ? 8 : 320;
      logic [31:0] mem     [1024];
      logic [31:0] sp_pipe [LAT];
      logic [31:0] sn_pipe [LAT];

      c2_sn_window_update #(.N(32), .AW(10), .N_SAMP(NS), .M_PITCH(MP), .RD_LAT(LAT)) u_dut (
         .i_clk(clk), .i_rst_n(rst_n), .i_start_frame(start[g]), .i_frame_base(base[g]),
         .i_shift_en(sh[g]), .i_load_zero(lz[g]),
         .o_spch_addr(spch_addr[g]), .o_spch_re(spch_re[g]), .i_spch_q(spch_q[g]),
         .o_sn_addr(sn_addr[g]), .o_sn_wdata(sn_wdata[g]), .o_sn_re(sn_re[g]),
         .o_sn_we(sn_we[g]), .i_sn_q(sn_q[g]),
         .o_busy(busy[g]), .o_done_frame(done[g]), .o_checksum(cks[g]));

      assign spch_q[g] = sp_pipe[LAT-1];
      assign sn_q[g]   = sn_pipe[LAT-1];

      always @(posedge clk) begin
         if (preload[g]) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'(i);
         end else if (sn_we[g]) begin
            mem[sn_addr[g]] <= sn_wdata[g];
         end
         sp_pipe[0] <= spch_re[g] ? 32'd1000 + 32'(spch_addr[g]) : 32'hDEAD_BEEF;
         sn_pipe[0] <= sn_re[g] ? mem[sn_addr[g]] : 32'hBAD0_BAD0;
         for (int i = 1; i < LAT; i++) begin
            sp_pipe[i] <= sp_pipe[i-1];
            sn_pipe[i] <= sn_pipe[i-1];
         end
      end
   end

   function automatic int lat_of(input int d); return (d == 0) ? 2 : (d == 1) ? 3 : 1; endfunction
   function automatic int ns_of(input int d);  return (d == 2) ? 8 : 80;  endfunction
   function automatic int mp_of(input int d);  return (d == 2) ? 8 : 320; endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      for (int g = 0; g < 3; g++) begin
         if (sn_we[g]) begin
            if (exp_q.size() == 0) begin
               n_extra++;
            end else begin
               e = exp_q.pop_front();
               chk("sn_addr", 32'(sn_addr[g]), 32'(e.a));
               chk("sn_wdata", sn_wdata[g], e.d);
            end
         end
         if (sn_we[g] && sn_re[g]) n_overlap++;
         if (spch_re[g]) n_spch++;
      end
   end

   task automatic do_preload(input int d);
      preload[d] = 1'b1;
      @(posedge clk); #1;
      preload[d] = 1'b0;
      for (int i = 0; i < 1024; i++) mdl[i] = i;
   endtask

   // extra_at / rst_at: cycle after acceptance at which to pulse start or assert reset (-1 = never)
   task automatic run_frame(input int d, input int fb, input bit s, input bit z,
                            input int extra_at, input int rst_at);
      int          ns, mp, sc, n, limit;
      logic [31:0] v, sum;
      ns  = ns_of(d);
      mp  = mp_of(d);
      sum = 0;
      if (s && ns < mp) begin
         for (int k = 0; k < mp - ns; k++) begin
            exp_q.push_back(wr_t'{a: 10'(k), d: 32'(mdl[k+ns])});
            mdl[k] = mdl[k+ns];
         end
      end
      for (int k = 0; k < ns; k++) begin
         v = z ? 32'd0 : 32'd1000 + 32'((fb + k) % 1024);
         exp_q.push_back(wr_t'{a: 10'(mp - ns + k), d: v});
         mdl[mp - ns + k] = int'(v);
         sum += v;
      end
      sc    = (s && ns < mp) ? mp : ns;
      limit = 2 * sc * (lat_of(d) + 2) + 20;
      n_extra = 0; n_overlap = 0; n_spch = 0;
      base[d] = 10'(fb); sh[d] = s; lz[d] = z;
      start[d] = 1'b1;
      @(posedge clk); #1;
      start[d] = 1'b0;
      chk("busy_after_start", 32'(busy[d]), 32'd1);
      n = 0;
      while (!done[d] && n < limit) begin
         start[d] = (n == extra_at);
         if (n == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_busy", 32'(busy[d]), 32'd0);
            chk("rst_sn_we", 32'(sn_we[d]), 32'd0);
            chk("rst_sn_addr", 32'(sn_addr[d]), 32'd0);
            chk("rst_checksum", cks[d], 32'd0);
            exp_q.delete();
            @(posedge clk); #1;
            rst_n = 1'b1;
            chk("rst_still_idle", 32'(busy[d]), 32'd0);
            return;
         end
         @(posedge clk); #1;
         n++;
      end
      start[d] = 1'b0;
      chk("done_latency", 32'(n), 32'(sc * (lat_of(d) + 2)));
      chk("checksum", cks[d], sum);
      chk("writes_left", 32'(exp_q.size()), 32'd0);
      chk("extra_writes", 32'(n_extra), 32'd0);
      chk("re_we_overlap", 32'(n_overlap), 32'd0);
      chk("spch_reads", 32'(n_spch), z ? 32'd0 : 32'(ns));
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("idle_done", 32'(done[d]), 32'd0);
         chk("idle_busy", 32'(busy[d]), 32'd0);
      end
      chk("checksum_held", cks[d], sum);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         start[d] = 1'b0; base[d] = '0; sh[d] = 1'b0; lz[d] = 1'b0; preload[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("reset_busy", 32'(busy[d]), 32'd0);
         chk("reset_done", 32'(done[d]), 32'd0);
         chk("reset_checksum", cks[d], 32'd0);
         chk("reset_ctrl", {28'd0, spch_re[d], sn_re[d], sn_we[d], 1'b0}, 32'd0);
         chk("reset_addr", {12'd0, spch_addr[d], sn_addr[d]}, 32'd0);
         chk("reset_wdata", sn_wdata[d], 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // default geometry, shift, with a stray start mid-frame
      do_preload(0);
      run_frame(0, 0, 1'b1, 1'b0, 500, -1);
      // initial fill, speech address wraps past 1023
      do_preload(0);
      run_frame(0, 1000, 1'b0, 1'b0, -1, -1);
      // end-of-stream flush
      do_preload(0);
      run_frame(0, 0, 1'b1, 1'b1, -1, -1);
      // longer read latency, same data
      do_preload(1);
      run_frame(1, 0, 1'b1, 1'b0, -1, -1);
      // reset mid-frame, then a normal frame
      do_preload(0);
      run_frame(0, 0, 1'b1, 1'b0, -1, 700);
      do_preload(0);
      run_frame(0, 37, 1'b1, 1'b0, -1, -1);
      // window equals frame step: no shift phase
      do_preload(2);
      run_frame(2, 5, 1'b1, 1'b0, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/c2_sn_window_update.md
# c2_sn_window_update

Parametrised analysis-window updater for the Codec2 encoder front end. On each frame request it slides the M_PITCH-sample speech window in the sn RAM left by N_SAMP samples. It then appends N_SAMP new samples, either read from the speech source RAM or zero-filled. It sits between the speech input RAM and the pitch/NLP stages, and it replaces single-shot test copy sequencers with one block that handles any RAM latency and window geometry.

## Interface
- N, 32: sample/data width (Q16.16 fixed point; not interpreted here)
- AW, 10: address width of both RAMs
- N_SAMP, 80: new samples per frame (frame step)
- M_PITCH, 320: window length in samples; requires 1 <= N_SAMP <= M_PITCH <= 2^AW
- RD_LAT, 2: read latency of both RAMs in cycles (re/addr to valid q); requires RD_LAT >= 1
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- start_frame  in  1  start request; sampled only in IDLE
- frame_base  in  AW  speech RAM address of the first new sample; latched at start
- shift_en  in  1  1 = run the shift phase; 0 = skip it (initial fill); latched at start
- load_zero  in  1  1 = append zeros and issue no speech reads (end-of-stream flush); latched at start
- spch_addr  out  AW  speech RAM address
- spch_re  out  1  speech RAM read enable
- spch_q  in  N  speech RAM read data
- sn_addr  out  AW  sn RAM address
- sn_wdata  out  N  sn RAM write data
- sn_re  out  1  sn RAM read enable
- sn_we  out  1  sn RAM write enable
- sn_q  in  N  sn RAM read data
- busy  out  1  high while a frame update is in progress
- done_frame  out  1  one-cycle completion pulse
- checksum  out  N  modulo-2^N sum of the N_SAMP appended samples; valid from done_frame until the next accepted start

## Operation
- States: IDLE, SH_RD, SH_WAIT, SH_WR, LD_RD, LD_WAIT, LD_WR, DONE.
- IDLE:
  - If start_frame=1: latch frame_base, shift_en and load_zero; clear k and checksum.
  - Go to SH_RD if shift_en=1 and N_SAMP<M_PITCH; otherwise go to LD_RD.
- Shift phase, for k = 0 .. M_PITCH-N_SAMP-1:
  - SH_RD: sn_addr=k+N_SAMP, sn_re=1.
  - SH_WAIT: lasts RD_LAT cycles, holding sn_addr and sn_re; sn_q is captured into the data register on the last wait cycle.
  - SH_WR: sn_addr=k, sn_we=1, sn_wdata=data register.
  - After SH_WR, k increments. On the final k, k resets to 0 and the next state is LD_RD.
- Load phase, for k = 0 .. N_SAMP-1:
  - LD_RD: spch_addr=frame_base+k (wraps modulo 2^AW), spch_re=1; spch_re is forced 0 when load_zero=1.
  - LD_WAIT: lasts RD_LAT cycles; spch_q is captured, or 0 when load_zero=1.
  - LD_WR: sn_addr=M_PITCH-N_SAMP+k, sn_we=1; checksum += captured value.
  - After the last LD_WR, the next state is DONE.
- DONE: done_frame=1 for one cycle, then IDLE.
- RAM controls are Moore decodes of state. Every control not named for a state is 0, and addresses/wdata are 0 in IDLE/DONE. sn_re and sn_we are never high together.
- busy=1 in all states except IDLE.
- start_frame while busy is ignored and is not queued.
- Reset mid-operation: immediately return to IDLE with all outputs at reset values. sn RAM contents are left partially updated; the caller re-issues the frame.

## Timing
- Reset values: state IDLE, busy=0, done_frame=0, checksum=0, all RAM address/enable/wdata outputs 0.
- Each sample costs RD_LAT+2 cycles.
- Latency: if start is accepted at edge E0, done_frame is high in the cycle after edge E0 + S*(RD_LAT+2).
  - S=M_PITCH with shift_en=1; S=N_SAMP with shift_en=0.
  - Defaults: 1280 cycles (shift) or 320 cycles (no shift).
- The earliest next start is accepted at the edge that ends the DONE cycle's successor (IDLE).
- Read data is sampled exactly RD_LAT cycles after the read cycle. Changing RD_LAT must change only the cycle counts, never the data written.

## Test plan
- Defaults, sn[i]=i, speech[j]=1000+j, frame_base=0, shift_en=1 -> sn[0..239]=80..319, sn[240..319]=1000..1079; checksum=83160; done_frame at cycle 1280.
- shift_en=0, frame_base=1000 (AW=10) -> speech addresses wrap 1000..1023, 0..55; sn[0..239] unchanged; done_frame at cycle 320.
- load_zero=1, shift_en=1 -> spch_re never asserted; sn[240..319]=0; checksum=0.
- RD_LAT=3, same data as the first scenario -> identical sn contents; done_frame at cycle 1600.
- Pulse start_frame at cycle 500 while busy, then assert rst at cycle 700 of a second frame -> the extra start is ignored; after reset: busy=0, sn_we=0, IDLE; a new start completes normally.
- N_SAMP=M_PITCH=8 -> shift phase skipped; 8 writes to sn[0..7] only.
